imem_uart_loader: RTL and testbench
===================================

Name: imem_uart_loader

Overview:
- Boot-time loader upstream of the single-cycle processor's instruction memory.
- Receives a raw memory image over a UART line (8N1, LSB first) and assembles little-endian bytes into 32-bit words.
- Writes each word into instruction memory at consecutive word addresses starting at 0.
- Raises w_done after the full image is written; the top level gates the processor clock/PC update with w_done, so the processor stays frozen until loading completes.
- Byte order matches the binary image dump: byte0 goes to bits [7:0].

Parameters:
CLKS_PER_BIT, 100, system clock cycles per UART bit; must be >= 4.
WORDS, 512, number of 32-bit words in one image; 1..2048.
ADDR_W, 11, width of the word address (matches the 2048-word memory).

Ports:
w_clk    in   1       system clock, all state on rising edge
w_rst    in   1       asynchronous, active-high reset
w_rxd    in   1       UART receive line, idle high, asynchronous to w_clk
w_we     out  1       instruction-memory write enable, one-cycle pulse per word
w_addr   out  ADDR_W  word address for the write (byte address >> 2)
w_wdata  out  32      assembled word
w_done   out  1       image complete, sticky until reset
w_err    out  1       framing error seen, sticky until reset

Behaviour:
- Reset (async, high):
  - w_we=0, w_addr=0, w_wdata=0, w_done=0, w_err=0.
  - Synchronizer flops=1, receive FSM=IDLE, bit/byte/word counters=0.
  - Reset mid-byte or mid-word discards all partial data; the next image restarts at address 0.
- Input sync:
  - w_rxd passes through a 2-flop synchronizer (reset value 1).
  - All decisions use the synchronized value.
- Receive FSM states: IDLE, START, DATA, STOP, WAITHI.
  - IDLE: synchronized line = 0 -> START, clear baud counter.
  - START: at count CLKS_PER_BIT/2 - 1 (mid start bit), line still 0 -> DATA; line 1 -> IDLE (glitch rejected, no error).
  - DATA: sample every CLKS_PER_BIT cycles from mid start bit. Bit i goes to shift[i], LSB first. After 8th sample -> STOP.
  - STOP: sample one bit period later.
    - Line 1: byte valid -> IDLE.
    - Line 0: byte discarded, w_err<=1 -> WAITHI.
  - WAITHI: stay until line = 1, then -> IDLE.
- Word assembly:
  - A byte counter 0..3 places each valid byte at word[8*k+7:8*k].
  - On the 4th valid byte:
    - Next cycle: w_we=1 for exactly one cycle, w_wdata=assembled word, w_addr=current word index.
    - Cycle after: word index increments, w_we=0.
    - Latency: 1 cycle from the stop-bit sample to the w_we pulse.
  - A framing error does not reset the byte counter; the bad byte simply does not count.
- Completion:
  - w_done rises in the same cycle as the w_we of word WORDS-1 plus one, i.e. the cycle after the last write.
  - Once w_done=1: further bytes are received (FSM keeps running) but ignored; no writes; w_addr holds WORDS-1.
- w_addr and w_wdata hold their last values between pulses.
- Only w_we qualifies them.
- The word index never wraps; with WORDS=2048 the last write goes to address 2047.
- All outputs are registered; no combinational path from w_rxd to any output.

Test Plan (CLKS_PER_BIT=16, WORDS=4 unless stated):
- Reset defaults: hold w_rst=1 with w_rxd toggling -> all outputs 0. Release, send nothing -> outputs remain 0.
- Send bytes 0x20,0x00,0x01,0x00 -> one w_we pulse with w_addr=0, w_wdata=0x00010020, 1 cycle after the 4th stop sample. w_done stays 0.
- Send 16 bytes encoding words 0x11111111, 0x22222222, 0x33333333, 0x1000FFFF:
  - Exactly four w_we pulses at addresses 0,1,2,3 with those data.
  - w_done=1 the cycle after the 4th write.
  - A 17th byte produces no w_we.
- Framing error: drive a frame with stop bit 0 after byte 0xAA, then line high.
  - w_err=1.
  - Byte not counted; next 4 good bytes 0x01,0x02,0x03,0x04 -> w_wdata=0x04030201 at address 0.
- Glitch: pulse w_rxd low for 4 cycles -> no byte received, w_err=0, no write.
- Reset mid-word: send 2 bytes, assert w_rst, release, send 0xEF,0xBE,0xAD,0xDE -> single write with w_addr=0, w_wdata=0xDEADBEEF.

Source files
------------

// File: rtl/imem_uart_loader_if.sv
// rtl/imem_uart_loader_if.sv - instruction-memory write port driven by the UART image loader
interface imem_uart_loader_if #(
  parameter int ADDR_W = 11
) ();
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_wdata;
  logic              w_done;
  logic              w_err;

  modport master (output w_we, output w_addr, output w_wdata, output w_done, output w_err);
  modport slave  (input  w_we, input  w_addr, input  w_wdata, input  w_done, input  w_err);
endinterface

// File: rtl/imem_uart_loader.sv
// rtl/imem_uart_loader.sv - UART 8N1 receiver that assembles little-endian words and writes them to instruction memory
module imem_uart_loader #(
  parameter int CLKS_PER_BIT = 100,
  parameter int WORDS        = 512,
  parameter int ADDR_W       = 11
) (
  input  logic                w_clk,
  input  logic                w_rst,
  input  logic                w_rxd,
  imem_uart_loader_if.master  mem
);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAITHI} state_t;

  localparam int                CW        = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0]     HALF_M1   = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]     FULL_M1   = CW'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);

  logic              rx_meta, rx_sync;
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              byte_ok, frame_bad;

  logic [1:0]        byte_cnt_q;
  logic [23:0]       word_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              done_q, err_q;

  // Line idles high, so the synchronizer resets to 1 to avoid a false start bit.
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= w_rxd;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_d     = bit_q;
    shift_d   = shift_q;
    byte_ok   = 1'b0;
    frame_bad = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_sync) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_sync ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d          = '0;
          shift_d[bit_q] = rx_sync;
          bit_d          = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (rx_sync) begin
            byte_ok = 1'b1;
            state_d = IDLE;
          end else begin
            frame_bad = 1'b1;
            state_d   = WAITHI;
          end
        end
      end
      WAITHI: begin
        cnt_d = '0;
        if (rx_sync) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The address advances (or completion latches) on the cycle after each write pulse.
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      byte_cnt_q <= '0;
      word_q     <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      we_q <= 1'b0;
      if (frame_bad) err_q <= 1'b1;
      if (we_q) begin
        if (addr_q == LAST_ADDR) done_q <= 1'b1;
        else                     addr_q <= addr_q + 1'b1;
      end
      if (byte_ok && !done_q) begin
        byte_cnt_q <= byte_cnt_q + 1'b1;
        case (byte_cnt_q)
          2'd0: word_q[7:0]   <= shift_q;
          2'd1: word_q[15:8]  <= shift_q;
          2'd2: word_q[23:16] <= shift_q;
          default: begin
            we_q    <= 1'b1;
            wdata_q <= {shift_q, word_q};
          end
        endcase
      end
    end
  end

  assign mem.w_we    = we_q;
  assign mem.w_addr  = addr_q;
  assign mem.w_wdata = wdata_q;
  assign mem.w_done  = done_q;
  assign mem.w_err   = err_q;
endmodule

// File: tb/tb_imem_uart_loader.sv
// tb/tb_imem_uart_loader.sv - directed self-checking bench for imem_uart_loader
module tb_imem_uart_loader;
  localparam int CPB    = 16;
  localparam int WORDS  = 4;
  localparam int ADDR_W = 11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxd = 1'b1;

  imem_uart_loader_if #(.ADDR_W(ADDR_W)) mem_if ();

  imem_uart_loader #(.CLKS_PER_BIT(CPB), .WORDS(WORDS), .ADDR_W(ADDR_W)) dut (
    .w_clk (clk),
    .w_rst (rst),
    .w_rxd (rxd),
    .mem   (mem_if.master)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          total = 0;
  int          bad   = 0;
  int          wr_count = 0;
  logic [31:0] wr_addr [64];
  logic [31:0] wr_data [64];
  int          wr_cyc  [64];
  int          done_cyc = -1;
  logic        done_prev = 1'b0;
  int          last_e0 = 0;
  int          base;

  always @(negedge clk) begin
    if (mem_if.w_we) begin
      if (wr_count < 64) begin
        wr_addr[wr_count] = 32'(mem_if.w_addr);
        wr_data[wr_count] = mem_if.w_wdata;
        wr_cyc[wr_count]  = cyc;
      end
      wr_count = wr_count + 1;
    end
    if (mem_if.w_done && !done_prev) done_cyc = cyc;
    done_prev = mem_if.w_done;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(posedge clk); #1;
    last_e0 = cyc;
    rxd = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(posedge clk); #1;
      rxd = b[i];
    end
    repeat (CPB) @(posedge clk); #1;
    rxd = stop_bit;
    repeat (CPB) @(posedge clk); #1;
    rxd = 1'b1;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk); #1;
  endtask

  function automatic logic [31:0] out_vec();
    return {mem_if.w_wdata[27:0], 1'b0, mem_if.w_we, mem_if.w_done, mem_if.w_err} ^
           {21'd0, mem_if.w_addr};
  endfunction

  logic [7:0]  img [16];
  logic [31:0] exp_words [4];

  initial begin
    exp_words[0] = 32'h11111111;
    exp_words[1] = 32'h22222222;
    exp_words[2] = 32'h33333333;
    exp_words[3] = 32'h1000FFFF;
    for (int w = 0; w < 4; w++)
      for (int k = 0; k < 4; k++)
        img[4*w+k] = exp_words[w][8*k +: 8];

    // reset held with the line toggling
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      rxd = ~rxd;
    end
    check("rst_we",    32'(mem_if.w_we),    32'd0);
    check("rst_addr",  32'(mem_if.w_addr),  32'd0);
    check("rst_wdata", mem_if.w_wdata,      32'd0);
    check("rst_done",  32'(mem_if.w_done),  32'd0);
    check("rst_err",   32'(mem_if.w_err),   32'd0);
    rxd = 1'b1;
    rst = 1'b0;
    repeat (50) @(posedge clk); #1;
    check("idle_outputs", out_vec(), 32'd0);
    check("idle_writes",  32'(wr_count), 32'd0);

    // single word 0x00010020
    base = wr_count;
    send_byte(8'h20, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    repeat (5) @(posedge clk); #1;
    check("w1_count", 32'(wr_count - base), 32'd1);
    check("w1_addr",  wr_addr[base], 32'd0);
    check("w1_data",  wr_data[base], 32'h00010020);
    check("w1_lat",   32'(wr_cyc[base]), 32'(last_e0 + 155));
    check("w1_done",  32'(mem_if.w_done), 32'd0);
    check("w1_hold_addr", 32'(mem_if.w_addr), 32'd1);
    check("w1_hold_data", mem_if.w_wdata, 32'h00010020);

    // full image of four words
    pulse_reset();
    base = wr_count;
    for (int i = 0; i < 16; i++) send_byte(img[i], 1'b1);
    repeat (5) @(posedge clk); #1;
    check("img_count", 32'(wr_count - base), 32'd4);
    for (int w = 0; w < 4; w++) begin
      check($sformatf("img_addr%0d", w), wr_addr[base+w], 32'(w));
      check($sformatf("img_data%0d", w), wr_data[base+w], exp_words[w]);
    end
    check("img_done",     32'(mem_if.w_done), 32'd1);
    check("img_done_cyc", 32'(done_cyc), 32'(wr_cyc[base+3] + 1));
    send_byte(8'h5A, 1'b1);
    repeat (5) @(posedge clk); #1;
    check("extra_count", 32'(wr_count - base), 32'd4);
    check("extra_addr",  32'(mem_if.w_addr), 32'd3);
    check("extra_done",  32'(mem_if.w_done), 32'd1);

    // framing error, then a good word
    pulse_reset();
    base = wr_count;
    send_byte(8'hAA, 1'b0);
    repeat (5) @(posedge clk); #1;
    check("fe_err",   32'(mem_if.w_err), 32'd1);
    check("fe_count", 32'(wr_count - base), 32'd0);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h04, 1'b1);
    repeat (5) @(posedge clk); #1;
    check("fe_wcount", 32'(wr_count - base), 32'd1);
    check("fe_addr",   wr_addr[base], 32'd0);
    check("fe_data",   wr_data[base], 32'h04030201);
    check("fe_sticky", 32'(mem_if.w_err), 32'd1);

    // short low glitch
    pulse_reset();
    base = wr_count;
    @(posedge clk); #1;
    rxd = 1'b0;
    repeat (4) @(posedge clk); #1;
    rxd = 1'b1;
    repeat (100) @(posedge clk); #1;
    check("gl_err",   32'(mem_if.w_err), 32'd0);
    check("gl_count", 32'(wr_count - base), 32'd0);

    // reset mid-word discards partial bytes
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    pulse_reset();
    base = wr_count;
    send_byte(8'hEF, 1'b1);
    send_byte(8'hBE, 1'b1);
    send_byte(8'hAD, 1'b1);
    send_byte(8'hDE, 1'b1);
    repeat (5) @(posedge clk); #1;
    check("mr_count", 32'(wr_count - base), 32'd1);
    check("mr_addr",  wr_addr[base], 32'd0);
    check("mr_data",  wr_data[base], 32'hDEADBEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
